// File: rtl/dcache_pkg.sv
// Shared configuration, address-field helpers and FSM state type for the
// direct-mapped write-through data cache.
package dcache_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 12;
  localparam int SETS           = 16;
  localparam int WORDS_PER_LINE = 4;

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam int WORD_AW = ADDR_WIDTH - 2;
  localparam int LINE_AW = IDX_W + OFF_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} dcache_state_t;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  function automatic logic [IDX_W-1:0] get_idx(input addr_t addr);
    return addr[2+OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input addr_t addr);
    return addr[ADDR_WIDTH-1 -: TAG_W];
  endfunction

  function automatic logic [OFF_W-1:0] get_woff(input addr_t addr);
    return addr[2 +: OFF_W];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and backing-memory-side signals of the data cache.
// master: the cache controller; slave: the core plus backing memory around it.
interface dcache_if;
  import dcache_pkg::*;

  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [3:0]            cpu_wstrb;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [WORD_AW-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_rdata, cpu_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_rdata, cpu_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/dcache_data_array.sv
// Cache data store: one flop word per (set, word offset), combinational
// read port and a single byte-enabled synchronous write port.
module dcache_data_array
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [LINE_AW-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic [LINE_AW-1:0]    raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] words [SETS*WORDS_PER_LINE];

  // NOTE: storage arrays get no reset; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) words[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = words[raddr];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Holds tags/valid bits and the IDLE/REFILL/WRITE sequencer; data lives in dcache_data_array.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  dcache_if.master    bus,
  output logic [31:0] miss_cnt
);

  dcache_state_t state, state_nxt;

  logic [OFF_W-1:0] beat;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-1:0] woff;
  logic             hit;
  logic             last_beat;
  logic             refill_beat;
  logic             refill_start;

  logic                  arr_we;
  logic [LINE_AW-1:0]    arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [3:0]            arr_wstrb;

  // The CPU holds its request stable while stalled, so it doubles as the miss address.
  assign idx  = get_idx(bus.cpu_addr);
  assign tag  = get_tag(bus.cpu_addr);
  assign woff = get_woff(bus.cpu_addr);

  assign hit          = valid[idx] && (tags[idx] == tag);
  assign last_beat    = (beat == OFF_W'(WORDS_PER_LINE - 1));
  assign refill_beat  = (state == REFILL) && bus.mem_ready;
  assign refill_start = (state == IDLE) && (state_nxt == REFILL);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a store wins over a simultaneous load.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.cpu_wr)              state_nxt = WRITE;
        else if (bus.cpu_rd && !hit) state_nxt = REFILL;
      end
      REFILL:  if (bus.mem_ready && last_beat) state_nxt = IDLE;
      WRITE:   if (bus.mem_ready)              state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    bus.cpu_stall = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    arr_we        = 1'b0;
    arr_waddr     = {idx, woff};
    arr_wdata     = bus.cpu_wdata;
    arr_wstrb     = bus.cpu_wstrb;
    unique case (state)
      IDLE: begin
        bus.cpu_stall = bus.cpu_wr || (bus.cpu_rd && !hit);
      end
      REFILL: begin
        bus.cpu_stall = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = {tag, idx, beat};
        arr_we        = bus.mem_ready;
        arr_waddr     = {idx, beat};
        arr_wdata     = bus.mem_rdata;
        arr_wstrb     = 4'hF;
      end
      WRITE: begin
        // Releasing the stall on the accepting beat lets the store retire without re-issue.
        bus.cpu_stall = !bus.mem_ready;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.cpu_addr[ADDR_WIDTH-1:2];
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_wstrb = bus.cpu_wstrb;
        arr_we        = bus.mem_ready && hit;
      end
      default: begin
        bus.cpu_stall = 1'b0;
      end
    endcase
  end

  // Valid bits, beat counter and miss counter
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat     <= '0;
      valid    <= '0;
      miss_cnt <= '0;
    end else begin
      if (refill_start) begin
        beat       <= '0;
        valid[idx] <= 1'b0;
        miss_cnt   <= miss_cnt + 32'd1;
      end
      if (refill_beat) begin
        beat <= beat + 1'b1;
        if (last_beat) valid[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (refill_beat && last_beat) tags[idx] <= tag;
  end

  dcache_data_array u_data (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wstrb (arr_wstrb),
    .raddr ({idx, woff}),
    .rdata (bus.cpu_rdata)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table-driven CPU accesses against a
// latency-programmable backing memory model, plus a reset-during-refill sequence.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  typedef enum {OP_RD, OP_WR, OP_RW} op_e;

  typedef struct {
    op_e         op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    int          stalls;
    logic [31:0] misses;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] miss_cnt;

  dcache_if bus ();

  dcache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  // Backing memory: mem_ready rises after 'lat' waiting cycles of an outstanding request.
  logic [31:0] bmem [1024];
  int          lat      = 0;
  int          wait_cnt = 0;

  assign bus.mem_ready = bus.mem_req && (wait_cnt >= lat);
  assign bus.mem_rdata = bmem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wstrb[b]) bmem[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end
    end
    if (!bus.mem_req || bus.mem_ready) wait_cnt <= 0;
    else                               wait_cnt <= wait_cnt + 1;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q [$];
  vec_t        vecs_a [$];
  vec_t        vecs_b [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one access, count stall cycles, then compare data, counters and bus state.
  task automatic apply_vec(input string tag_s, input int n, input vec_t v);
    int          stalls;
    logic [31:0] exp;
    @(negedge clk);
    lat           = v.lat;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    bus.cpu_wstrb = v.wstrb;
    bus.cpu_rd    = (v.op != OP_WR);
    bus.cpu_wr    = (v.op != OP_RD);
    if (v.op == OP_RD) sb_q.push_back(v.rdata);
    #1;
    stalls = 0;
    while (bus.cpu_stall && stalls < 100) begin
      stalls++;
      if (v.op != OP_RD && stalls > 1) begin
        check($sformatf("%s%0d_wait_we", tag_s, n), 32'(bus.mem_we), 32'd1);
        check($sformatf("%s%0d_wait_addr", tag_s, n), 32'(bus.mem_addr), 32'(v.addr[11:2]));
      end
      @(negedge clk);
      #1;
    end
    check($sformatf("%s%0d_stall_cycles", tag_s, n), 32'(stalls), 32'(v.stalls));
    if (v.op == OP_RD) begin
      exp = sb_q.pop_front();
      check($sformatf("%s%0d_rdata", tag_s, n), bus.cpu_rdata, exp);
      check($sformatf("%s%0d_no_mem_req", tag_s, n), 32'(bus.mem_req), 32'd0);
    end else begin
      check($sformatf("%s%0d_wr_beat", tag_s, n),
            {30'd0, bus.mem_req, bus.mem_we}, 32'd3);
      check($sformatf("%s%0d_wr_addr", tag_s, n), 32'(bus.mem_addr), 32'(v.addr[11:2]));
      check($sformatf("%s%0d_wr_data", tag_s, n), bus.mem_wdata, v.wdata);
      check($sformatf("%s%0d_wr_strb", tag_s, n), 32'(bus.mem_wstrb), 32'(v.wstrb));
    end
    check($sformatf("%s%0d_miss_cnt", tag_s, n), miss_cnt, v.misses);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) bmem[i] = 32'hC000_0000 | 32'(i);
    for (int i = 0; i < 4; i++)    bmem[16 + i] = 32'hA0 + 32'(i);

    //                   op     addr     wdata          strb  lat rdata          stalls miss
    vecs_a.push_back(vec_t'{OP_RD, 12'h040, 32'h0,         4'h0, 0, 32'h0000_00A0, 5,  32'd1});
    vecs_a.push_back(vec_t'{OP_RD, 12'h044, 32'h0,         4'h0, 0, 32'h0000_00A1, 0,  32'd1});
    vecs_a.push_back(vec_t'{OP_RD, 12'h048, 32'h0,         4'h0, 0, 32'h0000_00A2, 0,  32'd1});
    vecs_a.push_back(vec_t'{OP_RD, 12'h04C, 32'h0,         4'h0, 0, 32'h0000_00A3, 0,  32'd1});
    vecs_a.push_back(vec_t'{OP_WR, 12'h044, 32'h0000_BB00, 4'h2, 3, 32'h0,         4,  32'd1});
    vecs_a.push_back(vec_t'{OP_RD, 12'h044, 32'h0,         4'h0, 0, 32'h0000_BBA1, 0,  32'd1});
    vecs_a.push_back(vec_t'{OP_WR, 12'h800, 32'h1234_5678, 4'hF, 0, 32'h0,         1,  32'd1});
    vecs_a.push_back(vec_t'{OP_RD, 12'h800, 32'h0,         4'h0, 0, 32'h1234_5678, 5,  32'd2});
    vecs_a.push_back(vec_t'{OP_RD, 12'h140, 32'h0,         4'h0, 0, 32'hC000_0050, 5,  32'd3});
    vecs_a.push_back(vec_t'{OP_RD, 12'h040, 32'h0,         4'h0, 0, 32'h0000_00A0, 5,  32'd4});
    vecs_a.push_back(vec_t'{OP_RD, 12'h044, 32'h0,         4'h0, 0, 32'h0000_BBA1, 0,  32'd4});
    vecs_a.push_back(vec_t'{OP_WR, 12'h048, 32'hEE00_00FF, 4'h9, 1, 32'h0,         2,  32'd4});
    vecs_a.push_back(vec_t'{OP_RD, 12'h048, 32'h0,         4'h0, 0, 32'hEE00_00FF, 0,  32'd4});
    vecs_a.push_back(vec_t'{OP_RD, 12'h14C, 32'h0,         4'h0, 2, 32'hC000_0053, 13, 32'd5});
    vecs_a.push_back(vec_t'{OP_RW, 12'h900, 32'h0000_0011, 4'h1, 0, 32'h0,         1,  32'd5});
    vecs_a.push_back(vec_t'{OP_RD, 12'h148, 32'h0,         4'h0, 0, 32'hC000_0052, 0,  32'd5});
    vecs_a.push_back(vec_t'{OP_RD, 12'h048, 32'h0,         4'h0, 0, 32'hEE00_00FF, 5,  32'd6});
    vecs_a.push_back(vec_t'{OP_RD, 12'h900, 32'h0,         4'h0, 0, 32'hC000_0211, 5,  32'd7});

    vecs_b.push_back(vec_t'{OP_RD, 12'h044, 32'h0,         4'h0, 0, 32'h0000_BBA1, 5,  32'd1});
    vecs_b.push_back(vec_t'{OP_RD, 12'h080, 32'h0,         4'h0, 0, 32'hC000_0020, 5,  32'd2});
    vecs_b.push_back(vec_t'{OP_RD, 12'h084, 32'h0,         4'h0, 0, 32'hC000_0021, 0,  32'd2});
    vecs_b.push_back(vec_t'{OP_RD, 12'h048, 32'h0,         4'h0, 0, 32'hEE00_00FF, 0,  32'd2});

    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wstrb = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_mem_req",   32'(bus.mem_req),   32'd0);
    check("reset_mem_we",    32'(bus.mem_we),    32'd0);
    check("reset_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("reset_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("reset_miss_cnt",  miss_cnt,           32'd0);
    check("reset_stall",     32'(bus.cpu_stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs_a.size(); i++) apply_vec("a", i, vecs_a[i]);

    // Reset while beat 2 of a refill is on the bus
    @(negedge clk);
    lat          = 0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 12'h080;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_pre_req",  32'(bus.mem_req),  32'd1);
    check("midrst_pre_addr", 32'(bus.mem_addr), 32'h022);
    check("midrst_pre_miss", miss_cnt,          32'd8);
    rst = 1'b0;
    #1;
    check("midrst_mem_req",  32'(bus.mem_req),  32'd0);
    check("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_miss_cnt", miss_cnt,          32'd0);
    @(negedge clk);
    bus.cpu_rd = 1'b0;
    rst        = 1'b1;

    for (int i = 0; i < vecs_b.size(); i++) apply_vec("b", i, vecs_b[i]);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    @(negedge clk);
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
